// File: rtl/text_vga_render.sv
// Text-mode VGA raster engine: 640x480@60 timing, character RAM fetch,
// font lookup handoff, inverse video and blinking underline cursor.
module text_vga_render #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int BLINK_FRAMES = 32,
  parameter int H_VIS        = COLS * 8,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = ROWS * 8,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [12:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [7:0]  font_ascii,
  output logic [3:0]  font_line,
  input  logic [7:0]  font_row,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam int         FW      = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] BF   = FW'(BLINK_FRAMES);

  // Sideband that travels with each pixel; sync flags are active-high here
  // so that cleared pipeline registers mean "no sync pulse".
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] px;
    logic [2:0] ln;
    logic [6:0] col;
    logic [5:0] row;
  } stage_t;

  logic [9:0]    h, v;
  logic          vis0;
  logic [12:0]   addr0;
  stage_t        s0, s1, s2;
  logic [1:0]    vld_pipe;
  logic [FW-1:0] fcnt;
  logic          blink_on;
  logic          cursor_hit, pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // row*80 as row*64 + row*16
  assign addr0 = {1'b0, v[8:3], 6'b0} + {3'b0, v[8:3], 4'b0} + {6'b0, h[9:3]};
  assign vis0  = (h < H_VIS_L) && (v < V_VIS_L);

  always_comb begin
    s0     = '0;
    s0.hs  = (h >= HS_BEG) && (h < HS_END);
    s0.vs  = (v >= VS_BEG) && (v < VS_END);
    s0.fs  = (h == '0) && (v == '0);
    s0.px  = h[2:0];
    s0.ln  = v[2:0];
    s0.col = h[9:3];
    s0.row = v[8:3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr <= '0;
      s1        <= '0;
      s2        <= '0;
      vld_pipe  <= '0;
    end else begin
      if (vis0) char_addr <= addr0;
      s1       <= s0;
      s2       <= s1;
      vld_pipe <= {vld_pipe[0], vis0};
    end
  end

  assign font_ascii = {1'b0, char_data[6:0]};
  assign font_line  = {1'b0, s2.ln};
  assign cursor_hit = cursor_en & blink_on & (s2.col == cursor_col) &
                      (s2.row == cursor_row) & (&s2.ln[2:1]);
  assign pix        = font_row[3'd7 - s2.px] ^ char_data[7] ^ cursor_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= vld_pipe[1] ? (pix ? fg_color : bg_color) : 12'h000;
      vga_hs      <= ~s2.hs;
      vga_vs      <= ~s2.vs;
      frame_start <= s2.fs;
    end
  end

  // fcnt counts frames begun in the current blink phase; toggling on the
  // start of frame BLINK_FRAMES keeps each phase exactly BLINK_FRAMES long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (frame_start) begin
      if (fcnt == BF) begin
        fcnt     <= FW'(1);
        blink_on <= ~blink_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

endmodule
